// File: rtl/router_pkg.sv
// Shared definitions for the router output-port sink: FSM encoding,
// header field positions and router timing constants.
package router_pkg;

  localparam int BYTE_W       = 8;
  localparam int LEN_MSB      = 7;
  localparam int LEN_LSB      = 2;
  localparam int ADDR_MSB     = 1;
  localparam int ADDR_LSB     = 0;
  localparam int LEN_W        = LEN_MSB - LEN_LSB + 1;
  localparam int SOFT_RST_CYC = 30;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
    return hdr[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/router_port_sink_if.sv
// Router output-port read handshake: FIFO not-empty flag, data and read strobe.
// The router side is the master, the sink is the slave.
interface router_port_sink_if;
  import router_pkg::*;

  logic              vld_out;
  logic [BYTE_W-1:0] data_out;
  logic              read_enb;

  modport master (output vld_out, output data_out, input read_enb);
  modport slave  (input vld_out, input data_out, output read_enb);

endinterface

// File: rtl/router_sink_parity.sv
// Running XOR accumulator for packet parity: seeded with the header,
// accumulated over payload, compared against the received parity byte.
module router_sink_parity
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              seed_i,
  input  logic              acc_i,
  input  logic              clr_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              mismatch_o
);

  logic [BYTE_W-1:0] acc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (seed_i) begin
      acc_q <= data_i;
    end else if (acc_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  assign mismatch_o = (acc_q != data_i);

endmodule

// File: rtl/router_port_sink.sv
// Downstream consumer for one router output port: reads, reassembles and checks packets.
// Optional destination check is enabled by defining ROUTER_SINK_ADDR_CHECK_EN.
module router_port_sink
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         CNT_W   = 16,
  parameter int         IDLE_TO = 29
) (
  input  logic              clk,
  input  logic              resetn,
  router_port_sink_if.slave rtr,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_vld,
  output logic              byte_sop,
  output logic              byte_eop,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              parity_err,
  output logic              trunc_err,
  output logic              to_err,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  err_cnt
`ifdef ROUTER_SINK_ADDR_CHECK_EN
  ,
  output logic              addr_err
`endif
);

  localparam int REQ_W  = LEN_W + 1;
  localparam int IDLE_W = $clog2(IDLE_TO + 1);
  localparam int GAP_W  = $clog2(SOFT_RST_CYC);

  state_e             state_q;
  logic               rd_d_q;
  logic [REQ_W-1:0]   req_left_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   byte_cnt_q;
  logic [IDLE_W-1:0]  idle_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [BYTE_W-1:0]  byte_out_q;
  logic               byte_vld_q;
  logic               byte_sop_q;
  logic               byte_eop_q;
  logic               pkt_done_q;
  logic [LEN_W-1:0]   pkt_len_q;
  logic               parity_err_q;
  logic               trunc_err_q;
  logic               to_err_q;
  logic [CNT_W-1:0]   pkt_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic rd_en, hdr_cap, body_cap, par_cap, gap_hit, abort, idle_inc;
  logic parity_bad, addr_bad;

  // Requests stop as soon as req_left hits zero, so the last byte is never over-read.
  assign rd_en    = rtr.vld_out && (req_left_q != '0) && (state_q == S_HDR || state_q == S_BODY);
  assign hdr_cap  = rd_d_q && (state_q == S_HDR);
  assign body_cap = rd_d_q && (state_q == S_BODY);
  assign par_cap  = body_cap && (byte_cnt_q == len_q);
  assign gap_hit  = (state_q == S_BODY) && !rtr.vld_out && (req_left_q != '0);
  assign abort    = gap_hit && (gap_cnt_q == GAP_W'(SOFT_RST_CYC - 1));
  assign idle_inc = rtr.vld_out && !rd_en && (idle_cnt_q != IDLE_W'(IDLE_TO));

  assign rtr.read_enb = rd_en;

`ifdef ROUTER_SINK_ADDR_CHECK_EN
  logic hdr_addr_bad_q;
  logic addr_err_q;
  assign addr_bad = hdr_addr_bad_q;
  assign addr_err = addr_err_q;
`else
  logic unused_port_id;
  assign addr_bad       = 1'b0;
  assign unused_port_id = ^PORT_ID;
`endif

  router_sink_parity u_parity (
    .clk        (clk),
    .resetn     (resetn),
    .seed_i     (hdr_cap),
    .acc_i      (body_cap && !par_cap),
    .clr_i      (par_cap || abort),
    .data_i     (rtr.data_out),
    .mismatch_o (parity_bad)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      rd_d_q       <= 1'b0;
      req_left_q   <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      byte_out_q   <= '0;
      byte_vld_q   <= 1'b0;
      byte_sop_q   <= 1'b0;
      byte_eop_q   <= 1'b0;
      pkt_done_q   <= 1'b0;
      pkt_len_q    <= '0;
      parity_err_q <= 1'b0;
      trunc_err_q  <= 1'b0;
      to_err_q     <= 1'b0;
      pkt_cnt_q    <= '0;
      err_cnt_q    <= '0;
`ifdef ROUTER_SINK_ADDR_CHECK_EN
      hdr_addr_bad_q <= 1'b0;
      addr_err_q     <= 1'b0;
`endif
    end else begin
      rd_d_q      <= rd_en;
      byte_vld_q  <= hdr_cap || body_cap;
      byte_sop_q  <= hdr_cap;
      byte_eop_q  <= par_cap;
      pkt_done_q  <= 1'b0;
      trunc_err_q <= 1'b0;
      to_err_q    <= idle_inc && (idle_cnt_q == IDLE_W'(IDLE_TO - 1));
      if (hdr_cap || body_cap) byte_out_q <= rtr.data_out;

      // Idle counter saturates at IDLE_TO while the port stays stalled.
      if (idle_inc) idle_cnt_q <= idle_cnt_q + 1'b1;
      else if (!rtr.vld_out || rd_en) idle_cnt_q <= '0;

      gap_cnt_q <= (gap_hit && !abort) ? gap_cnt_q + 1'b1 : '0;
      if (rd_en) req_left_q <= req_left_q - 1'b1;

      case (state_q)
        S_IDLE: begin
          if (rtr.vld_out) begin
            state_q    <= S_HDR;
            req_left_q <= REQ_W'(1);
          end
        end
        S_HDR: begin
          if (hdr_cap) begin
            state_q    <= S_BODY;
            len_q      <= hdr_len(rtr.data_out);
            req_left_q <= {1'b0, hdr_len(rtr.data_out)} + REQ_W'(1);
            byte_cnt_q <= '0;
`ifdef ROUTER_SINK_ADDR_CHECK_EN
            hdr_addr_bad_q <= (rtr.data_out[ADDR_MSB:ADDR_LSB] != PORT_ID);
`endif
          end
        end
        S_BODY: begin
          if (abort) begin
            state_q     <= S_IDLE;
            req_left_q  <= '0;
            trunc_err_q <= 1'b1;
            err_cnt_q   <= err_cnt_q + 1'b1;
          end else if (par_cap) begin
            state_q      <= S_DONE;
            pkt_done_q   <= 1'b1;
            pkt_len_q    <= len_q;
            parity_err_q <= parity_bad;
            pkt_cnt_q    <= pkt_cnt_q + 1'b1;
            if (parity_bad || addr_bad) err_cnt_q <= err_cnt_q + 1'b1;
`ifdef ROUTER_SINK_ADDR_CHECK_EN
            addr_err_q <= hdr_addr_bad_q;
`endif
          end else if (body_cap) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_vld   = byte_vld_q;
  assign byte_sop   = byte_sop_q;
  assign byte_eop   = byte_eop_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_len    = pkt_len_q;
  assign parity_err = parity_err_q;
  assign trunc_err  = trunc_err_q;
  assign to_err     = to_err_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_router_port_sink.sv
// Directed bench for router_port_sink: a FIFO model plays the router port,
// a negedge monitor collects sink outputs, check_eq compares against expectations.
module tb_router_port_sink;
  import router_pkg::*;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  router_port_sink_if rif ();

  logic [7:0]  byte_out;
  logic        byte_vld, byte_sop, byte_eop, pkt_done;
  logic [5:0]  pkt_len;
  logic        parity_err, trunc_err, to_err;
  logic [15:0] pkt_cnt, err_cnt;
`ifdef ROUTER_SINK_ADDR_CHECK_EN
  logic        addr_err;
`endif

  router_port_sink #(.PORT_ID(2'd1), .CNT_W(16), .IDLE_TO(29)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rtr        (rif),
    .byte_out   (byte_out),
    .byte_vld   (byte_vld),
    .byte_sop   (byte_sop),
    .byte_eop   (byte_eop),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .trunc_err  (trunc_err),
    .to_err     (to_err),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt)
`ifdef ROUTER_SINK_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  bq_t fifo_q, exp_q, rx_q;
  logic rd_pend = 1'b0;
  int rden_cnt = 0;
  int vld_cnt = 0, sop_cnt = 0, eop_cnt = 0, done_cnt = 0, perr_cnt = 0;
  int trunc_cnt = 0, to_cnt = 0;
  logic [7:0] sop_byte = '0, eop_byte = '0;
  logic [5:0] last_len = '0;
  logic last_perr = 1'b0;
  logic last_aerr = 1'b0;

  // Router port model: a read strobe seen at a posedge pops the FIFO for the next cycle.
  initial begin
    rif.vld_out  = 1'b0;
    rif.data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        check_eq("no_overread", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) rif.data_out = fifo_q.pop_front();
      end
      rif.vld_out = resetn && (fifo_q.size() != 0);
      #1;
      rd_pend = rif.read_enb;
      if (rd_pend) rden_cnt++;
    end
  end

  always @(negedge clk) begin
    if (byte_vld) begin
      vld_cnt++;
      rx_q.push_back(byte_out);
      if (byte_sop) begin sop_cnt++; sop_byte = byte_out; end
      if (byte_eop) begin eop_cnt++; eop_byte = byte_out; end
    end
    if (pkt_done) begin
      done_cnt++;
      last_len  = pkt_len;
      last_perr = parity_err;
      if (parity_err) perr_cnt++;
`ifdef ROUTER_SINK_ADDR_CHECK_EN
      last_aerr = addr_err;
`endif
      $display("pkt_done: len=%0d parity_err=%0b pkt_cnt=%0d err_cnt=%0d",
               pkt_len, parity_err, pkt_cnt, err_cnt);
    end
    if (trunc_err) begin
      trunc_cnt++;
      $display("trunc_err: err_cnt=%0d", err_cnt);
    end
    if (to_err) to_cnt++;
  end

  function automatic bq_t mk_pkt(input logic [7:0] hdr, input int seed, input bit flip);
    bq_t p;
    logic [7:0] par;
    p.push_back(hdr);
    par = hdr;
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      logic [7:0] b;
      b = 8'(seed * 31 + i * 53 + 7) | 8'h01;
      p.push_back(b);
      par = par ^ b;
    end
    p.push_back(par ^ {7'd0, flip});
    return p;
  endfunction

  task automatic send_range(input bq_t p, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      fifo_q.push_back(p[i]);
      exp_q.push_back(p[i]);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    vld_cnt = 0; sop_cnt = 0; eop_cnt = 0; done_cnt = 0; perr_cnt = 0;
    trunc_cnt = 0; rden_cnt = 0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input int n, input string tag);
    for (int i = 0; i < 300 && done_cnt < n; i++) cycles(1);
    check_eq(tag, done_cnt, n);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && fifo_q.size() != 0; i++) cycles(1);
    cycles(3);
  endtask

  task automatic check_rx(input string tag);
    check_eq({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check_eq({tag, "_byte"}, rx_q[i], exp_q[i]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p;
    #1 resetn = 1'b0;
    cycles(3);
    check_eq("rst_read_enb", rif.read_enb, 1'b0);
    check_eq("rst_byte_vld", byte_vld, 1'b0);
    check_eq("rst_pkt_done", pkt_done, 1'b0);
    check_eq("rst_pkt_cnt", pkt_cnt, 16'd0);
    check_eq("rst_err_cnt", err_cnt, 16'd0);
    @(negedge clk) resetn = 1'b1;
    cycles(2);

    // Single packet, header 0x39: L=14, addr 01
    clear_stats();
    p = mk_pkt(8'h39, 1, 1'b0);
    send_range(p, 0, 15);
    wait_done(1, "t1_done");
    check_eq("t1_byte_vld_cnt", vld_cnt, 16);
    check_eq("t1_sop_cnt", sop_cnt, 1);
    check_eq("t1_sop_byte", sop_byte, 8'h39);
    check_eq("t1_eop_cnt", eop_cnt, 1);
    check_eq("t1_eop_byte", eop_byte, p[15]);
    check_eq("t1_pkt_len", last_len, 6'd14);
    check_eq("t1_parity_err", last_perr, 1'b0);
    check_eq("t1_pkt_cnt", pkt_cnt, 16'd1);
    check_eq("t1_err_cnt", err_cnt, 16'd0);
    check_eq("t1_read_enb_cycles", rden_cnt, 16);
`ifdef ROUTER_SINK_ADDR_CHECK_EN
    check_eq("t1_addr_err", last_aerr, 1'b0);
`endif
    check_rx("t1");

    // Bad parity, header 0x46: L=17
    clear_stats();
    p = mk_pkt(8'h46, 2, 1'b1);
    send_range(p, 0, 18);
    wait_done(1, "t2_done");
    check_eq("t2_parity_err", last_perr, 1'b1);
    check_eq("t2_pkt_len", last_len, 6'd17);
    check_eq("t2_pkt_cnt", pkt_cnt, 16'd2);
    check_eq("t2_err_cnt", err_cnt, 16'd1);
    check_rx("t2");

    // Zero payload then 3-byte payload, back to back
    clear_stats();
    p = mk_pkt(8'h01, 3, 1'b0);
    check_eq("t3_zero_len_parity", p[1], 8'h01);
    send_range(p, 0, 1);
    p = mk_pkt(8'h0D, 4, 1'b0);
    send_range(p, 0, 4);
    wait_done(2, "t3_done");
    check_eq("t3_perr_cnt", perr_cnt, 0);
    check_eq("t3_last_len", last_len, 6'd3);
    check_eq("t3_sop_cnt", sop_cnt, 2);
    check_eq("t3_eop_cnt", eop_cnt, 2);
    check_eq("t3_pkt_cnt", pkt_cnt, 16'd4);
    check_eq("t3_err_cnt", err_cnt, 16'd1);
    check_rx("t3");

    // Short vld_out gap mid-payload stalls reading only
    clear_stats();
    p = mk_pkt(8'h29, 5, 1'b0);
    send_range(p, 0, 4);
    wait_drain();
    rden_cnt = 0;
    cycles(5);
    check_eq("t4a_gap_read_enb_cycles", rden_cnt, 0);
    send_range(p, 5, 11);
    wait_done(1, "t4a_done");
    check_eq("t4a_parity_err", last_perr, 1'b0);
    check_eq("t4a_pkt_len", last_len, 6'd10);
    check_eq("t4a_trunc_cnt", trunc_cnt, 0);
    check_eq("t4a_pkt_cnt", pkt_cnt, 16'd5);
    check_rx("t4a");

    // Long gap aborts the packet
    clear_stats();
    p = mk_pkt(8'h29, 6, 1'b0);
    send_range(p, 0, 4);
    wait_drain();
    cycles(40);
    check_eq("t4b_trunc_cnt", trunc_cnt, 1);
    check_eq("t4b_done_cnt", done_cnt, 0);
    check_eq("t4b_err_cnt", err_cnt, 16'd2);
    check_eq("t4b_pkt_cnt", pkt_cnt, 16'd5);
    check_eq("t4b_read_enb", rif.read_enb, 1'b0);

    // Clean packet after the abort
    clear_stats();
    p = mk_pkt(8'h0D, 7, 1'b0);
    send_range(p, 0, 4);
    wait_done(1, "t4c_done");
    check_eq("t4c_parity_err", last_perr, 1'b0);
    check_eq("t4c_pkt_len", last_len, 6'd3);
    check_eq("t4c_pkt_cnt", pkt_cnt, 16'd6);
    check_eq("t4c_err_cnt", err_cnt, 16'd2);
    check_rx("t4c");

    // Reset after the 4th payload byte, checked before the next clock edge
    clear_stats();
    p = mk_pkt(8'h21, 8, 1'b0);
    send_range(p, 0, 4);
    wait_drain();
    check_eq("t5_pre_byte_vld_cnt", vld_cnt, 5);
    #1 resetn = 1'b0;
    #1;
    check_eq("t5_rst_pkt_cnt", pkt_cnt, 16'd0);
    check_eq("t5_rst_err_cnt", err_cnt, 16'd0);
    check_eq("t5_rst_pkt_len", pkt_len, 6'd0);
    check_eq("t5_rst_byte_out", byte_out, 8'h00);
    check_eq("t5_rst_byte_vld", byte_vld, 1'b0);
    check_eq("t5_rst_read_enb", rif.read_enb, 1'b0);
    @(negedge clk) resetn = 1'b1;
    cycles(2);
    clear_stats();
    p = mk_pkt(8'h0D, 9, 1'b0);
    send_range(p, 0, 4);
    wait_done(1, "t5_done");
    check_eq("t5_parity_err", last_perr, 1'b0);
    check_eq("t5_pkt_len", last_len, 6'd3);
    check_eq("t5_pkt_cnt", pkt_cnt, 16'd1);
    check_eq("t5_err_cnt", err_cnt, 16'd0);
    check_eq("t5_trunc_cnt", trunc_cnt, 0);
    check_rx("t5");

`ifdef ROUTER_SINK_ADDR_CHECK_EN
    // Header 0x3A targets port 2, this sink serves port 1
    clear_stats();
    p = mk_pkt(8'h3A, 10, 1'b0);
    send_range(p, 0, 15);
    wait_done(1, "t6_done");
    check_eq("t6_addr_err", last_aerr, 1'b1);
    check_eq("t6_parity_err", last_perr, 1'b0);
    check_eq("t6_pkt_cnt", pkt_cnt, 16'd2);
    check_eq("t6_err_cnt", err_cnt, 16'd1);
    check_rx("t6");
`endif

    check_eq("no_idle_timeout", to_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
